// File: rtl/pipe_run_ctrl_if.sv
// Host command channel for the pipeline run controller (valid/ready handshake).
interface pipe_run_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;

    // Host side drives commands.
    modport master (
        output cmd_valid,
        output cmd,
        input  cmd_ready
    );

    // Controller side accepts commands.
    modport slave (
        input  cmd_valid,
        input  cmd,
        output cmd_ready
    );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline: gates pipe_en, squashes fetch
// after HALT reaches ID, drains the back end, and counts cycles and retirements.
module pipe_run_ctrl #(
    parameter int unsigned          NB_CNT      = 32,
    parameter int unsigned          DRAIN_DEPTH = 3,
    parameter logic [NB_CNT-1:0]    MAX_CYCLES  = {NB_CNT{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    pipe_run_ctrl_if.slave      cmd_if,
    input  logic                halt_detect,
    input  logic                wb_valid,
    output logic                pipe_en,
    output logic                flush_if,
    output logic                pipe_clear,
    output logic                done,
    output logic                timeout,
    output logic [2:0]          state,
    output logic [NB_CNT-1:0]   cycle_count,
    output logic [NB_CNT-1:0]   instr_count
);

    localparam int unsigned DrainW = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;

    localparam logic [1:0] CmdRun   = 2'b00;
    localparam logic [1:0] CmdStep  = 2'b01;
    localparam logic [1:0] CmdPause = 2'b10;
    localparam logic [1:0] CmdClear = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StStep   = 3'd2,
        StDrain  = 3'd3,
        StHalted = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [NB_CNT-1:0]   cycle_count_q, cycle_count_d;
    logic [NB_CNT-1:0]   instr_count_q, instr_count_d;
    logic                timeout_q, timeout_d;
    logic                pipe_clear_q, pipe_clear_d;
    logic                accept;
    logic                clr_cnt;

    // Moore outputs decoded from the current state.
    always_comb begin
        pipe_en          = 1'b0;
        flush_if         = 1'b0;
        done             = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        unique case (state_q)
            StIdle:   cmd_if.cmd_ready = 1'b1;
            StRun:    begin pipe_en = 1'b1; cmd_if.cmd_ready = 1'b1; end
            StStep:   pipe_en = 1'b1;
            StDrain:  begin pipe_en = 1'b1; flush_if = 1'b1; end
            StHalted: begin done = 1'b1; cmd_if.cmd_ready = 1'b1; end
            default:  ;
        endcase
    end

    assign accept = cmd_if.cmd_valid & cmd_if.cmd_ready;

    // Next-state: command decode, halt/drain sequencing and watchdog.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        timeout_d    = timeout_q;
        pipe_clear_d = 1'b0;
        clr_cnt      = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (cmd_if.cmd)
                        CmdRun:   state_d = StRun;
                        CmdStep:  state_d = StStep;
                        CmdClear: begin pipe_clear_d = 1'b1; clr_cnt = 1'b1; end
                        default:  ;
                    endcase
                end
            end
            StRun: begin
                if (halt_detect) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainW'(DRAIN_DEPTH - 1);
                end else if (accept && cmd_if.cmd == CmdPause) begin
                    state_d = StIdle;
                end else if (cycle_count_q + NB_CNT'(1) == MAX_CYCLES) begin
                    state_d   = StHalted;
                    timeout_d = 1'b1;
                end
            end
            StStep: begin
                if (halt_detect) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainW'(DRAIN_DEPTH - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                // ID only holds bubbles here, so halt_detect is not looked at.
                if (drain_cnt_q == '0) state_d = StHalted;
                else                   drain_cnt_d = drain_cnt_q - DrainW'(1);
            end
            StHalted: begin
                if (accept && cmd_if.cmd == CmdClear) begin
                    state_d      = StIdle;
                    pipe_clear_d = 1'b1;
                    clr_cnt      = 1'b1;
                    timeout_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Cycle and retirement counters, both gated by the pipeline enable.
    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (clr_cnt) begin
            cycle_count_d = '0;
            instr_count_d = '0;
        end else if (pipe_en) begin
            cycle_count_d = cycle_count_q + NB_CNT'(1);
            if (wb_valid) instr_count_d = instr_count_q + NB_CNT'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            drain_cnt_q   <= '0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
            timeout_q     <= 1'b0;
            pipe_clear_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
            timeout_q     <= timeout_d;
            pipe_clear_q  <= pipe_clear_d;
        end
    end

    assign pipe_clear  = pipe_clear_q;
    assign timeout     = timeout_q;
    assign state       = state_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: main instance with default watchdog, second
// instance with MAX_CYCLES=20 for the watchdog scenario.
module tb_pipe_run_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Main instance
    pipe_run_ctrl_if m_if ();
    logic        halt_detect, wb_valid;
    logic        pipe_en, flush_if, pipe_clear, done, timeout;
    logic [2:0]  state;
    logic [31:0] cycle_count, instr_count;

    pipe_run_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_if      (m_if),
        .halt_detect (halt_detect),
        .wb_valid    (wb_valid),
        .pipe_en     (pipe_en),
        .flush_if    (flush_if),
        .pipe_clear  (pipe_clear),
        .done        (done),
        .timeout     (timeout),
        .state       (state),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    // Watchdog instance
    pipe_run_ctrl_if w_if ();
    logic        w_pipe_en, w_flush_if, w_pipe_clear, w_done, w_timeout;
    logic [2:0]  w_state;
    logic [31:0] w_cycle_count, w_instr_count;

    pipe_run_ctrl #(.MAX_CYCLES(32'd20)) u_wd (
        .clk         (clk),
        .reset       (reset),
        .cmd_if      (w_if),
        .halt_detect (1'b0),
        .wb_valid    (1'b0),
        .pipe_en     (w_pipe_en),
        .flush_if    (w_flush_if),
        .pipe_clear  (w_pipe_clear),
        .done        (w_done),
        .timeout     (w_timeout),
        .state       (w_state),
        .cycle_count (w_cycle_count),
        .instr_count (w_instr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        m_if.cmd_valid = 1'b1;
        m_if.cmd       = c;
        tick();
        m_if.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (pipe_en !== 1'b0) begin n_err++; $display("FAIL reset_pipe_en: got %b expected 0", pipe_en); end
        n_cmp++; if (m_if.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", m_if.cmd_ready); end
        n_cmp++; if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", cycle_count, instr_count); end
        n_cmp++; if (timeout !== 1'b0 || pipe_clear !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags: got t=%b c=%b d=%b expected 0", timeout, pipe_clear, done); end
    endtask

    task automatic test_run_pause();
        int en_cycles;
        send_cmd(2'b10); // PAUSE in IDLE is ignored
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_pause_ignored: got %0d expected 0", state); end
        send_cmd(2'b00);
        en_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (pipe_en === 1'b1) en_cycles++;
            tick();
        end
        if (pipe_en === 1'b1) en_cycles++;
        send_cmd(2'b10);
        n_cmp++; if (en_cycles !== 11) begin n_err++; $display("FAIL pause_en_cycles: got %0d expected 11", en_cycles); end
        n_cmp++; if (cycle_count !== 32'd11) begin n_err++; $display("FAIL pause_cycle_count: got %0d expected 11", cycle_count); end
        n_cmp++; if (state !== 3'd0 || pipe_en !== 1'b0) begin n_err++; $display("FAIL pause_state: got %0d/%b expected 0/0", state, pipe_en); end
        send_cmd(2'b00);
        repeat (3) tick();
        n_cmp++; if (cycle_count !== 32'd14) begin n_err++; $display("FAIL resume_count: got %0d expected 14", cycle_count); end
        send_cmd(2'b10);
        n_cmp++; if (cycle_count !== 32'd15 || state !== 3'd0) begin n_err++; $display("FAIL resume_pause: got %0d/%0d expected 15/0", cycle_count, state); end
    endtask

    task automatic test_step();
        do_reset();
        wb_valid = 1'b1;
        tick(); // wb_valid while frozen must not count
        for (int i = 0; i < 3; i++) begin
            send_cmd(2'b01);
            n_cmp++; if (state !== 3'd2 || m_if.cmd_ready !== 1'b0 || pipe_en !== 1'b1) begin n_err++; $display("FAIL step_cycle%0d: got st=%0d rdy=%b en=%b expected 2/0/1", i, state, m_if.cmd_ready, pipe_en); end
            tick();
        end
        wb_valid = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL step_back_idle: got %0d expected 0", state); end
        n_cmp++; if (cycle_count !== 32'd3 || instr_count !== 32'd3) begin n_err++; $display("FAIL step_counts: got %0d/%0d expected 3/3", cycle_count, instr_count); end
    endtask

    task automatic test_halt_drain();
        do_reset();
        send_cmd(2'b00);
        repeat (4) tick();
        halt_detect = 1'b1;
        tick();
        halt_detect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (flush_if !== 1'b1 || state !== 3'd3) begin n_err++; $display("FAIL drain_flush%0d: got f=%b st=%0d expected 1/3", i, flush_if, state); end
            tick();
        end
        n_cmp++; if (done !== 1'b1 || state !== 3'd4 || flush_if !== 1'b0) begin n_err++; $display("FAIL halted: got d=%b st=%0d f=%b expected 1/4/0", done, state, flush_if); end
        n_cmp++; if (cycle_count !== 32'd8) begin n_err++; $display("FAIL halt_cycle_count: got %0d expected 8", cycle_count); end
        send_cmd(2'b00);
        n_cmp++; if (state !== 3'd4 || pipe_en !== 1'b0) begin n_err++; $display("FAIL halted_run_ignored: got %0d/%b expected 4/0", state, pipe_en); end
        send_cmd(2'b11);
        n_cmp++; if (pipe_clear !== 1'b1 || state !== 3'd0 || cycle_count !== 32'd0) begin n_err++; $display("FAIL clear: got pc=%b st=%0d cc=%0d expected 1/0/0", pipe_clear, state, cycle_count); end
        tick();
        n_cmp++; if (pipe_clear !== 1'b0) begin n_err++; $display("FAIL clear_pulse_width: got %b expected 0", pipe_clear); end
    endtask

    task automatic test_watchdog();
        do_reset();
        w_if.cmd_valid = 1'b1;
        w_if.cmd       = 2'b00;
        tick();
        w_if.cmd_valid = 1'b0;
        repeat (19) tick();
        n_cmp++; if (w_state !== 3'd1 || w_timeout !== 1'b0 || w_cycle_count !== 32'd19) begin n_err++; $display("FAIL wd_before: got st=%0d t=%b cc=%0d expected 1/0/19", w_state, w_timeout, w_cycle_count); end
        tick();
        n_cmp++; if (w_state !== 3'd4 || w_timeout !== 1'b1 || w_cycle_count !== 32'd20 || w_done !== 1'b1) begin n_err++; $display("FAIL wd_fire: got st=%0d t=%b cc=%0d expected 4/1/20", w_state, w_timeout, w_cycle_count); end
        w_if.cmd_valid = 1'b1;
        w_if.cmd       = 2'b11;
        tick();
        w_if.cmd_valid = 1'b0;
        n_cmp++; if (w_timeout !== 1'b0 || w_state !== 3'd0 || w_pipe_clear !== 1'b1) begin n_err++; $display("FAIL wd_clear: got t=%b st=%0d pc=%b expected 0/0/1", w_timeout, w_state, w_pipe_clear); end
    endtask

    task automatic test_halt_vs_pause_and_reset();
        do_reset();
        send_cmd(2'b00);
        repeat (2) tick();
        halt_detect    = 1'b1;
        m_if.cmd_valid = 1'b1;
        m_if.cmd       = 2'b10;
        tick();
        halt_detect    = 1'b0;
        m_if.cmd_valid = 1'b0;
        n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL halt_beats_pause: got %0d expected 3", state); end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++; if (state !== 3'd0 || flush_if !== 1'b0) begin n_err++; $display("FAIL reset_in_drain: got st=%0d f=%b expected 0/0", state, flush_if); end
        n_cmp++; if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin n_err++; $display("FAIL reset_in_drain_counts: got %0d/%0d expected 0/0", cycle_count, instr_count); end
    endtask

    initial begin
        reset          = 1'b0;
        halt_detect    = 1'b0;
        wb_valid       = 1'b0;
        m_if.cmd_valid = 1'b0;
        m_if.cmd       = 2'b00;
        w_if.cmd_valid = 1'b0;
        w_if.cmd       = 2'b00;
        test_reset();
        test_run_pause();
        test_step();
        test_halt_drain();
        test_watchdog();
        test_halt_vs_pause_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
- Run/step/halt sequencer for the 5-stage MIPS pipeline (NB_addr=5, NB_data=32 datapath).
- Gates the global pipeline enable and squashes fetch after a HALT instruction reaches ID, then drains EX/MEM/WB before declaring completion.
- Counts executed cycles and retired instructions; takes commands from the debug/host interface through a valid/ready handshake.

Parameters:
- NB_CNT, 32, width of cycle_count and instr_count.
- DRAIN_DEPTH, 3, number of enabled cycles after HALT is seen in ID (EX, MEM, WB).
- MAX_CYCLES, 32'hFFFF_FFFF, run-cycle watchdog limit; reaching it forces HALTED with timeout=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; reset=0 at a rising edge resets the block.
- cmd_valid  in  1  host command valid.
- cmd  in  2  command: 00 RUN, 01 STEP, 10 PAUSE, 11 CLEAR.
- cmd_ready  out  1  block can accept a command.
- halt_detect  in  1  HALT opcode present in ID this cycle (qualified by pipe_en).
- wb_valid  in  1  non-bubble instruction retiring in WB this cycle.
- pipe_en  out  1  global pipeline/PC enable; 0 freezes all stage registers.
- flush_if  out  1  insert bubble into IF/ID and hold PC.
- pipe_clear  out  1  one-cycle pulse that resets the PC and pipeline registers.
- done  out  1  program finished (HALTED state).
- timeout  out  1  sticky watchdog flag.
- state  out  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- cycle_count  out  NB_CNT  cycles with pipe_en=1 (wraps).
- instr_count  out  NB_CNT  retirements (wb_valid & pipe_en) (wraps).

Behaviour:
- Reset: state=IDLE, cycle_count=0, instr_count=0, timeout=0, pipe_clear=0. Reset overrides any command or in-flight drain.
- Moore outputs:
  - pipe_en=1 in RUN, STEP and DRAIN only.
  - flush_if=1 in DRAIN only.
  - done=1 in HALTED only.
  - cmd_ready=1 in IDLE, RUN and HALTED; 0 in STEP and DRAIN.
- A command is accepted when cmd_valid & cmd_ready at a rising edge. The new state applies from the next cycle, so pipe_en rises one cycle after acceptance.
- A command that is invalid for the current state is consumed and ignored, with no state change.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP.
  - CLEAR -> IDLE, with pipe_clear=1 for the next cycle and both counters zeroed.
  - PAUSE is ignored.
- RUN:
  - halt_detect -> DRAIN, loading drain_cnt=DRAIN_DEPTH-1.
  - Otherwise, PAUSE -> IDLE. The pipeline is frozen in place and can be resumed by RUN.
  - Otherwise, if cycle_count+1 == MAX_CYCLES -> HALTED with timeout set.
  - Priority: halt_detect > PAUSE > watchdog. RUN, STEP and CLEAR are ignored.
- STEP: exactly one enabled cycle, then IDLE. If halt_detect is high in that cycle, go to DRAIN instead.
- DRAIN:
  - Runs for DRAIN_DEPTH enabled cycles with flush_if=1, decrementing drain_cnt.
  - Moves to HALTED in the cycle after drain_cnt==0.
  - halt_detect is ignored (only bubbles are in ID). The watchdog is not checked.
- HALTED: only CLEAR is acted on -> IDLE, with pipe_clear pulse, counters zeroed and timeout cleared.
- Counters:
  - cycle_count += 1 in every cycle with pipe_en=1.
  - instr_count += 1 when wb_valid & pipe_en. wb_valid with pipe_en=0 is not counted.
  - Both counters wrap modulo 2^NB_CNT.
- halt_detect and wb_valid are ignored whenever pipe_en=0.

Test Plan:
- Reset=0 for 3 cycles, then release -> state=0, pipe_en=0, cmd_ready=1, counters=0.
- RUN, then 10 cycles, then PAUSE -> pipe_en high exactly 10+1 cycles (including the PAUSE accept cycle), cycle_count=11, state=IDLE. A second RUN resumes with the counter continuing from 11.
- 3 STEP commands, each with wb_valid=1 -> cycle_count=3, instr_count=3, cmd_ready=0 during each STEP cycle.
- RUN, then halt_detect at run cycle 5 -> flush_if=1 for 3 cycles, done=1 from the following cycle, cycle_count=8. A subsequent RUN is ignored; CLEAR -> pipe_clear 1-cycle pulse, counters=0, state=IDLE.
- MAX_CYCLES=20, RUN, no halt -> state=HALTED after cycle_count=20, timeout=1. halt_detect and PAUSE in the same cycle in RUN -> DRAIN wins.
- Reset=0 asserted in the middle of DRAIN -> next cycle state=IDLE, flush_if=0, counters=0.
